// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops, radix-2 Booth multiplier, optional restoring divider.
// The divider is compiled only when SEQ_ALU_DIV_EN is defined; otherwise op 4 reports ill.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               dz,
    output logic               ill,
    output logic [1:0]         dbg_state
);
    localparam int SW = $clog2(WIDTH);

`ifdef SEQ_ALU_DIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIN = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, FIN = 2'd3} state_t;
`endif

    // Handshake: start is sampled only in IDLE; done pulses for one cycle with result,
    // dz and ill valid, and those outputs hold until the next accepted start.
    state_t           state;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic             q1;
    logic [SW-1:0]    cnt;

    logic [SW-1:0]      sh_n;
    logic [3*WIDTH-1:0] tri_a;
    logic [3*WIDTH-1:0] ror_w;
    logic [3*WIDTH-1:0] rol_w;
    logic [WIDTH-1:0]   alu_val;
    logic               alu_ok;

    // Rotates use a tripled copy of a so any count below 2*WIDTH wraps correctly.
    always_comb begin
        sh_n    = b[SW-1:0];
        tri_a   = {a, a, a};
        ror_w   = tri_a >> sh_n;
        rol_w   = tri_a << sh_n;
        alu_ok  = 1'b1;
        alu_val = '0;
        case (op)
            4'd1:    alu_val = a + b;
            4'd2:    alu_val = a - b;
            4'd5:    alu_val = a >> sh_n;
            4'd6:    alu_val = a << sh_n;
            4'd7:    alu_val = ror_w[WIDTH-1:0];
            4'd8:    alu_val = rol_w[3*WIDTH-1:2*WIDTH];
            4'd9:    alu_val = a & b;
            4'd10:   alu_val = a | b;
            4'd11:   alu_val = -a;
            4'd12:   alu_val = ~a;
            default: alu_ok  = 1'b0;
        endcase
    end

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   bsum;
    logic [WIDTH:0]   acc_b;
    logic [WIDTH-1:0] q_b;

    // Booth step on {acc, q, q1}; acc carries one guard bit so acc - (-2^(W-1)) cannot overflow.
    always_comb begin
        m_ext = {m[WIDTH-1], m};
        case ({q[0], q1})
            2'b01:   bsum = acc + m_ext;
            2'b10:   bsum = acc - m_ext;
            default: bsum = acc;
        endcase
        acc_b = {bsum[WIDTH], bsum[WIDTH:1]};
        q_b   = {bsum[0], q[WIDTH-1:1]};
    end

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH+1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] quo_f;
    logic [WIDTH-1:0] rem_f;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             neg_q;
    logic             neg_r;

    // Unsigned restoring division on magnitudes; signs are applied on the final step.
    always_comb begin
        r_sh  = {acc[WIDTH-1:0], q[WIDTH-1]};
        diff  = {1'b0, r_sh} - {2'b00, m};
        ge    = ~diff[WIDTH+1];
        rem_d = ge ? diff[WIDTH:0] : r_sh;
        q_d   = {q[WIDTH-2:0], ge};
        quo_f = neg_q ? -q_d : q_d;
        rem_f = neg_r ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
        a_mag = a[WIDTH-1] ? -a : a;
        b_mag = b[WIDTH-1] ? -b : b;
    end
`else
    assign dz = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            done   <= 1'b0;
            result <= '0;
            ill    <= 1'b0;
            acc    <= '0;
            q      <= '0;
            m      <= '0;
            q1     <= 1'b0;
            cnt    <= '0;
`ifdef SEQ_ALU_DIV_EN
            dz     <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ill <= 1'b0;
                        cnt <= '0;
`ifdef SEQ_ALU_DIV_EN
                        dz  <= 1'b0;
`endif
                        if (op == 4'd3) begin
                            acc   <= '0;
                            q     <= b;
                            m     <= a;
                            q1    <= 1'b0;
                            state <= MUL;
                        end
`ifdef SEQ_ALU_DIV_EN
                        else if (op == 4'd4 && b != '0) begin
                            acc   <= '0;
                            q     <= a_mag;
                            m     <= b_mag;
                            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r <= a[WIDTH-1];
                            state <= DIV;
                        end else if (op == 4'd4) begin
                            result <= '0;
                            dz     <= 1'b1;
                            done   <= 1'b1;
                            state  <= FIN;
                        end
`endif
                        else begin
                            result <= {{WIDTH{1'b0}}, alu_val};
                            ill    <= ~alu_ok;
                            done   <= 1'b1;
                            state  <= FIN;
                        end
                    end
                end
                MUL: begin
                    acc <= acc_b;
                    q   <= q_b;
                    q1  <= q[0];
                    cnt <= cnt + SW'(1);
                    if (cnt == SW'(WIDTH - 1)) begin
                        result <= {acc_b[WIDTH-1:0], q_b};
                        done   <= 1'b1;
                        state  <= FIN;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                DIV: begin
                    acc <= rem_d;
                    q   <= q_d;
                    cnt <= cnt + SW'(1);
                    if (cnt == SW'(WIDTH - 1)) begin
                        result <= {rem_f, quo_f};
                        done   <= 1'b1;
                        state  <= FIN;
                    end
                end
`endif
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=32): vector table, random mul/div against native arithmetic,
// and hand-written sequences for busy-start, start-in-done-cycle and mid-operation clr.
module tb_seq_alu;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           clr;
    logic           start;
    logic [3:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           dz;
    logic           ill;
    logic [1:0]     dbg_state;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .dz(dz), .ill(ill),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        int             lat;
        logic [2*W-1:0] res;
        logic           dz;
        logic           ill;
    } vec_t;

    vec_t             vecs[$];
    logic [2*W+1:0]   exp_q[$];
    int               n_pass = 0;
    int               n_total = 0;

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic add_vec(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           input int lat, input logic [2*W-1:0] res, input logic edz, input logic eill);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.lat = lat; v.res = res; v.dz = edz; v.ill = eill;
        vecs.push_back(v);
    endtask

    // Drives one accepted start, scrambles inputs while busy, then waits (bounded) for done.
    task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int lat, input logic [2*W-1:0] res,
                          input logic edz, input logic eill);
        int cyc;
        logic [2*W+1:0] e;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        exp_q.push_back({edz, eill, res});
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 200);
        check({name, " latency"}, 72'(cyc), 72'(lat));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (done) begin
            check({name, " result"}, 72'({dz, ill, result}), 72'(e));
            @(negedge clk);
            check({name, " pulse/hold"}, 72'({done, result}), 72'({1'b0, e[2*W-1:0]}));
        end
    endtask

    initial begin
        logic [W-1:0]          x, y;
        logic signed [2*W-1:0] px, py;
        logic signed [W-1:0]   sx, sy, quo, rem;
        logic [2*W+1:0]        e;
        int                    cyc, ndone, lat;
        logic [2*W+1:0]        got;

        add_vec(4'd1,  32'hFFFFFFFF, 32'd1,        1, 64'h0, 1'b0, 1'b0);
        add_vec(4'd1,  32'h7FFFFFFF, 32'd1,        1, 64'h80000000, 1'b0, 1'b0);
        add_vec(4'd2,  32'd5,        32'd7,        1, 64'hFFFFFFFE, 1'b0, 1'b0);
        add_vec(4'd5,  32'hF0000000, 32'd4,        1, 64'h0F000000, 1'b0, 1'b0);
        add_vec(4'd5,  32'h12345678, 32'd32,       1, 64'h12345678, 1'b0, 1'b0);
        add_vec(4'd6,  32'd1,        32'd31,       1, 64'h80000000, 1'b0, 1'b0);
        add_vec(4'd6,  32'hFFFFFFFF, 32'h24,       1, 64'hFFFFFFF0, 1'b0, 1'b0);
        add_vec(4'd7,  32'h80000001, 32'd4,        1, 64'h18000000, 1'b0, 1'b0);
        add_vec(4'd7,  32'h12345678, 32'd0,        1, 64'h12345678, 1'b0, 1'b0);
        add_vec(4'd8,  32'h80000001, 32'd4,        1, 64'h00000018, 1'b0, 1'b0);
        add_vec(4'd8,  32'h12345678, 32'd8,        1, 64'h34567812, 1'b0, 1'b0);
        add_vec(4'd9,  32'hF0F0F0F0, 32'hFF00FF00, 1, 64'hF000F000, 1'b0, 1'b0);
        add_vec(4'd10, 32'hF0F0F0F0, 32'h0F00000F, 1, 64'hFFF0F0FF, 1'b0, 1'b0);
        add_vec(4'd11, 32'd5,        32'd9,        1, 64'hFFFFFFFB, 1'b0, 1'b0);
        add_vec(4'd11, 32'h80000000, 32'd0,        1, 64'h80000000, 1'b0, 1'b0);
        add_vec(4'd12, 32'd0,        32'd3,        1, 64'hFFFFFFFF, 1'b0, 1'b0);
        add_vec(4'd12, 32'hA5A5A5A5, 32'd0,        1, 64'h5A5A5A5A, 1'b0, 1'b0);
        add_vec(4'd3,  32'hFFFFFFFD, 32'd7,       33, 64'hFFFFFFFFFFFFFFEB, 1'b0, 1'b0);
        add_vec(4'd3,  32'h80000000, 32'h80000000, 33, 64'h4000000000000000, 1'b0, 1'b0);
        add_vec(4'd3,  32'h7FFFFFFF, 32'hFFFFFFFF, 33, 64'hFFFFFFFF80000001, 1'b0, 1'b0);
        add_vec(4'd14, 32'd5,        32'd6,        1, 64'h0, 1'b0, 1'b1);
        add_vec(4'd1,  32'd2,        32'd3,        1, 64'h5, 1'b0, 1'b0);
        add_vec(4'd0,  32'd5,        32'd6,        1, 64'h0, 1'b0, 1'b1);
        add_vec(4'd15, 32'd5,        32'd6,        1, 64'h0, 1'b0, 1'b1);
`ifdef SEQ_ALU_DIV_EN
        add_vec(4'd4,  32'hFFFFFFF9, 32'd2,       33, 64'hFFFFFFFFFFFFFFFD, 1'b0, 1'b0);
        add_vec(4'd4,  32'd100,      32'd7,       33, 64'h000000020000000E, 1'b0, 1'b0);
        add_vec(4'd4,  32'd7,        32'hFFFFFFFE, 33, 64'h00000001FFFFFFFD, 1'b0, 1'b0);
        add_vec(4'd4,  32'h80000000, 32'hFFFFFFFF, 33, 64'h0000000080000000, 1'b0, 1'b0);
        add_vec(4'd4,  32'd5,        32'd0,        1, 64'h0, 1'b1, 1'b0);
        add_vec(4'd1,  32'd1,        32'd1,        1, 64'h2, 1'b0, 1'b0);
`else
        add_vec(4'd4,  32'd8,        32'd2,        1, 64'h0, 1'b0, 1'b1);
`endif

        clr = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset state", 72'({busy, done, dz, ill, result}), 72'(0));
        @(posedge clk);
        #1 clr = 1'b0;

        foreach (vecs[i])
            run_op($sformatf("vec%0d op%0d", i, vecs[i].op), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].lat, vecs[i].res, vecs[i].dz, vecs[i].ill);

        for (int i = 0; i < 6; i++) begin
            x = $urandom; y = $urandom;
            px = $signed(x); py = $signed(y);
            run_op($sformatf("rnd mul %0d", i), 4'd3, x, y, 33, 64'(px * py), 1'b0, 1'b0);
        end
`ifdef SEQ_ALU_DIV_EN
        for (int i = 0; i < 6; i++) begin
            x = $urandom;
            y = $urandom >> $urandom_range(0, 31);
            if (y == 0) y = 3;
            if ($urandom_range(0, 1) == 1) y = -y;
            if (x == 32'h80000000) x = 32'd1;
            sx = $signed(x); sy = $signed(y);
            quo = sx / sy; rem = sx % sy;
            run_op($sformatf("rnd div %0d", i), 4'd4, x, y, 33, {rem, quo}, 1'b0, 1'b0);
        end
`endif

        // start held high for the whole multiply with changing operands
        @(negedge clk);
        op = 4'd3; a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
        exp_q.push_back({2'b00, 64'hFFFFFFFFFFFFFFEB});
        @(posedge clk);
        #1;
        cyc = 0; ndone = 0; lat = 0; got = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    lat = cyc;
                    got = {dz, ill, result};
                    start = 1'b0;
                end
            end else if (ndone == 0) begin
                op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
            end
        end
        start = 1'b0;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("busy start done count", 72'(ndone), 72'(1));
        check("busy start latency", 72'(lat), 72'(33));
        check("busy start result", 72'(got), 72'(e));

        // start raised in the done cycle is taken one cycle later
        run_op("pre done-cycle", 4'd1, 32'd10, 32'd20, 1, 64'd30, 1'b0, 1'b0);
        @(negedge clk);
        op = 4'd1; a = 32'd10; b = 32'd20; start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 10);
        op = 4'd1; a = 32'd1; b = 32'd2;
        exp_q.push_back({2'b00, 64'd3});
        @(posedge clk);
        #1 check("start in done cycle ignored", 72'({busy, done}), 72'(0));
        @(posedge clk);
        #1 start = 1'b0;
        check("start after done accepted", 72'(busy), 72'(1));
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("done-cycle follow-on result", 72'({done, dz, ill, result}), 72'({1'b1, e}));

        // clr mid-multiply clears outputs without a clock edge
        @(negedge clk);
        op = 4'd3; a = 32'd5; b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #2 clr = 1'b1;
        #1 check("async clr outputs", 72'({busy, done, dz, ill, result, dbg_state}), 72'(0));
        @(posedge clk);
        #1 clr = 1'b0;
        run_op("after clr", 4'd1, 32'd2, 32'd3, 1, 64'd5, 1'b0, 1'b0);
        check("scoreboard drained", 72'(exp_q.size()), 72'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: got no finish, expected finish before 500000");
        $fatal(1, "timeout");
    end
endmodule
